sdram_rw_arbiter: RTL and testbench

//  Schedules the single SDRAM command port among three requesters: auto-refresh, burst write (wfifo drain)
//  and burst read (rfifo fill). Consumes wr_trig/rd_trig, owns the refresh timer and generates burst

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_ref_timer.sv | 40 ++++
 rtl/sdram_rw_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_rw_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM read/write/refresh arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } arb_state_e;

  localparam logic GNT_WRITE = 1'b0;
  localparam logic GNT_READ  = 1'b1;

  localparam int REF_CNT_DEF   = 780;
  localparam int BURST_LEN_DEF = 256;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh period timer: raises aref_req every REF_CNT clocks once init_done is seen,
// and flags ref_miss if a period expires while the previous request is still outstanding.
module sdram_ref_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_CNT = REF_CNT_DEF
) (
  input  logic wfifo_rclk,
  input  logic s_rst_n,
  input  logic init_done,
  input  logic aref_done,
  output logic aref_req,
  output logic ref_miss
);

  localparam int CNT_W = $clog2(REF_CNT);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  // Down-counter reloads at terminal count, giving one wrap every REF_CNT clocks.
  assign wrap = running && (cnt == '0);

  always_ff @(posedge wfifo_rclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      running  <= 1'b0;
      cnt      <= CNT_W'(REF_CNT - 1);
      aref_req <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      if (init_done) running <= 1'b1;
      if (running) cnt <= wrap ? CNT_W'(REF_CNT - 1) : cnt - 1'b1;
      if (wrap) aref_req <= 1'b1;
      else if (aref_done) aref_req <= 1'b0;
      if (wrap && aref_req && !aref_done) ref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates the SDRAM command port among refresh, write burst and read burst; owns burst addresses.
// Optional PINGPONG_BANK_EN: double frame buffer selected by the address MSB.
//   state | meaning
//   IDLE  | waiting for init_done
//   ARB   | pick refresh > alternating write/read
//   AREF  | refresh granted, wait aref_end
//   WRITE | write burst granted, wait wr_end
//   READ  | read burst granted, wait rd_end
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REF_CNT     = REF_CNT_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int ADDR_W      = 24,
  parameter int FRAME_WORDS = 786432
) (
  input  logic              wfifo_rclk,
  input  logic              s_rst_n,
  input  logic              init_done,
  input  logic              wr_trig,
  input  logic              rd_trig,
  output logic              aref_en,
  input  logic              aref_end,
  output logic              wr_en,
  input  logic              wr_end,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  input  logic              rd_end,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ref_miss,
  output logic [2:0]        arb_state
);

  localparam int FRAME_BURSTS = FRAME_WORDS / BURST_LEN;

  arb_state_e state, state_nxt;
  logic       last_grant;
  logic       aref_req;
  logic       aref_done, wr_done, rd_done;
  logic       wr_elig, rd_elig;

  assign aref_done = (state == AREF)  && aref_end;
  assign wr_done   = (state == WRITE) && wr_end;
  assign rd_done   = (state == READ)  && rd_end;

  sdram_ref_timer #(.REF_CNT(REF_CNT)) u_ref_timer (
    .wfifo_rclk (wfifo_rclk),
    .s_rst_n    (s_rst_n),
    .init_done  (init_done),
    .aref_done  (aref_done),
    .aref_req   (aref_req),
    .ref_miss   (ref_miss)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (init_done) state_nxt = ARB;
      ARB: begin
        if (aref_req) state_nxt = AREF;
        else if (wr_elig && (!rd_elig || last_grant == GNT_READ)) state_nxt = WRITE;
        else if (rd_elig) state_nxt = READ;
      end
      AREF:  if (aref_end) state_nxt = ARB;
      WRITE: if (wr_end)   state_nxt = ARB;
      READ:  if (rd_end)   state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wfifo_rclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_READ;
    end else begin
      state <= state_nxt;
      if (state == ARB && state_nxt == WRITE) last_grant <= GNT_WRITE;
      else if (state == ARB && state_nxt == READ) last_grant <= GNT_READ;
    end
  end

  assign aref_en   = (state == AREF);
  assign wr_en     = (state == WRITE);
  assign rd_en     = (state == READ);
  assign arb_state = state;

`ifdef PINGPONG_BANK_EN
  logic [ADDR_W-2:0] wr_off, rd_off;
  logic [ADDR_W-1:0] wr_step, rd_step;
  logic              wr_bank, rd_bank, done_bank, frame_done;

  assign wr_step = {1'b0, wr_off} + ADDR_W'(BURST_LEN);
  assign rd_step = {1'b0, rd_off} + ADDR_W'(BURST_LEN);
  assign wr_elig = wr_trig;
  assign rd_elig = rd_trig && frame_done;
  assign wr_addr = {wr_bank, wr_off};
  assign rd_addr = {rd_bank, rd_off};

  // Reader jumps to whichever bank most recently received a full frame.
  always_ff @(posedge wfifo_rclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_off     <= '0;
      rd_off     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      done_bank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_done) begin
        if (wr_step == ADDR_W'(FRAME_WORDS)) begin
          wr_off     <= '0;
          wr_bank    <= ~wr_bank;
          done_bank  <= wr_bank;
          frame_done <= 1'b1;
        end else begin
          wr_off <= wr_step[ADDR_W-2:0];
        end
      end
      if (rd_done) begin
        if (rd_step == ADDR_W'(FRAME_WORDS)) begin
          rd_off  <= '0;
          rd_bank <= done_bank;
        end else begin
          rd_off <= rd_step[ADDR_W-2:0];
        end
      end
    end
  end
`else
  localparam int OCC_W = $clog2(FRAME_BURSTS) + 1;

  logic [OCC_W-1:0] occ;
  logic [ADDR_W:0]  wr_step, rd_step;

  assign wr_step = {1'b0, wr_addr} + (ADDR_W+1)'(BURST_LEN);
  assign rd_step = {1'b0, rd_addr} + (ADDR_W+1)'(BURST_LEN);
  assign wr_elig = wr_trig && (occ < OCC_W'(FRAME_BURSTS));
  assign rd_elig = rd_trig && (occ != '0);

  always_ff @(posedge wfifo_rclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      occ     <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      if (wr_done) occ <= occ + 1'b1;
      else if (rd_done) occ <= occ - 1'b1;
      if (wr_done)
        wr_addr <= (wr_step == (ADDR_W+1)'(FRAME_WORDS)) ? '0 : wr_step[ADDR_W-1:0];
      if (rd_done)
        rd_addr <= (rd_step == (ADDR_W+1)'(FRAME_WORDS)) ? '0 : rd_step[ADDR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed self-checking bench for sdram_rw_arbiter (default single-buffer build).
module tb_sdram_rw_arbiter;

  logic        wfifo_rclk = 1'b0;
  logic        s_rst_n;
  logic        init_done, wr_trig, rd_trig;
  logic        aref_end, wr_end, rd_end;
  logic        aref_en, wr_en, rd_en, ref_miss;
  logic [23:0] wr_addr, rd_addr;
  logic [2:0]  arb_state;

  int vecs   = 0;
  int misses = 0;

  sdram_rw_arbiter dut (
    .wfifo_rclk (wfifo_rclk),
    .s_rst_n    (s_rst_n),
    .init_done  (init_done),
    .wr_trig    (wr_trig),
    .rd_trig    (rd_trig),
    .aref_en    (aref_en),
    .aref_end   (aref_end),
    .wr_en      (wr_en),
    .wr_end     (wr_end),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_end     (rd_end),
    .rd_addr    (rd_addr),
    .ref_miss   (ref_miss),
    .arb_state  (arb_state)
  );

  always #5 wfifo_rclk = ~wfifo_rclk;

  task automatic tick();
    @(posedge wfifo_rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
      else begin
        misses++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic pulse_aref();
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
  endtask

  // Wait for a burst grant (servicing refreshes), check it, hold, end it and check release.
  task automatic do_grant(input logic [2:0] exp_ens, input int hold,
                          input logic [23:0] exp_addr, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (aref_en) pulse_aref();
      else if (wr_en || rd_en) got = 1'b1;
      else tick();
    end
    chk({tag, " grant seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " enables"}, 32'({aref_en, wr_en, rd_en}), 32'(exp_ens));
      chk({tag, " addr"}, 32'(wr_en ? wr_addr : rd_addr), 32'(exp_addr));
      repeat (hold) tick();
      if (wr_en) wr_end = 1'b1;
      else rd_end = 1'b1;
      tick();
      wr_end = 1'b0;
      rd_end = 1'b0;
      chk({tag, " release"}, 32'({aref_en, wr_en, rd_en}), 32'd0);
    end
  endtask

  initial begin
    bit any, blocked;
    s_rst_n   = 1'b0;
    init_done = 1'b0;
    wr_trig   = 1'b0;
    rd_trig   = 1'b0;
    aref_end  = 1'b0;
    wr_end    = 1'b0;
    rd_end    = 1'b0;
    repeat (3) tick();
    chk("reset enables", 32'({aref_en, wr_en, rd_en}), 32'd0);
    chk("reset state", 32'(arb_state), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset ref_miss", 32'(ref_miss), 32'd0);
    s_rst_n = 1'b1;

    // 1: no activity before init_done
    wr_trig = 1'b1;
    any = 1'b0;
    repeat (2000) begin
      tick();
      if ({aref_en, wr_en, rd_en} != 3'b000 || arb_state != 3'd0) any = 1'b1;
    end
    chk("t1 activity before init", 32'(any), 32'd0);
    chk("t1 state idle", 32'(arb_state), 32'd0);
    chk("t1 aref_req", 32'(dut.u_ref_timer.aref_req), 32'd0);

    // 2: write-only bursts, grant latency and release timing
    init_done = 1'b1;
    tick();
    chk("t2 enter arb", 32'(arb_state), 32'd1);
    chk("t2 wr_en in arb", 32'(wr_en), 32'd0);
    tick();
    chk("t2 wr_en rise", 32'(wr_en), 32'd1);
    chk("t2 state write", 32'(arb_state), 32'd3);
    chk("t2 wr_addr 0", 32'(wr_addr), 32'd0);
    repeat (299) tick();
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("t2 wr_en fall", 32'(wr_en), 32'd0);
    chk("t2 wr_addr 256", 32'(wr_addr), 32'd256);
    tick();
    chk("t2 second grant", 32'(wr_en), 32'd1);
    repeat (299) tick();
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("t2 wr_addr 512", 32'(wr_addr), 32'd512);
    tick();
    chk("t2 third grant", 32'(wr_en), 32'd1);

    // 4: refresh period expires mid-write; no preemption, then wins over pending read
    rd_trig = 1'b1;
    repeat (300) tick();
    chk("t4 aref_req pending", 32'(dut.u_ref_timer.aref_req), 32'd1);
    chk("t4 no preempt", 32'({aref_en, wr_en, rd_en}), 32'b010);
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("t4 arb gap", 32'({aref_en, wr_en, rd_en}), 32'd0);
    tick();
    chk("t4 aref over read", 32'({aref_en, wr_en, rd_en}), 32'b100);
    repeat (800) tick();
    chk("t4 ref_miss set", 32'(ref_miss), 32'd1);
    pulse_aref();
    chk("t4 aref_en fall", 32'(aref_en), 32'd0);

    // 3: alternating grants, last_grant was WRITE so read goes first
    do_grant(3'b001, 2, 24'd0,    "t3 r0");
    do_grant(3'b010, 2, 24'd768,  "t3 w0");
    do_grant(3'b001, 2, 24'd256,  "t3 r1");
    do_grant(3'b010, 2, 24'd1024, "t3 w1");
    chk("t3 occ", 32'(dut.occ), 32'd3);
    chk("t3 rd_addr", 32'(rd_addr), 32'd512);
    chk("t3 ref_miss sticky", 32'(ref_miss), 32'd1);

    // 5: fill the frame, wrap the write address, hit the occupancy ceiling
    rd_trig = 1'b0;
    for (int i = 0; i < 3067; i++)
      do_grant(3'b010, 0, 24'(((5 + i) % 3072) * 256), "t5 fill");
    chk("t5 wr_addr wrap", 32'(wr_addr), 32'd0);
    do_grant(3'b010, 0, 24'd0,   "t5 w3072");
    do_grant(3'b010, 0, 24'd256, "t5 w3073");
    chk("t5 occ full", 32'(dut.occ), 32'd3072);
    blocked = 1'b0;
    repeat (30) begin
      if (aref_en) pulse_aref();
      else tick();
      if (wr_en) blocked = 1'b1;
    end
    chk("t5 write blocked", 32'(blocked), 32'd0);
    rd_trig = 1'b1;
    do_grant(3'b001, 0, 24'd512, "t5 read");
    do_grant(3'b010, 0, 24'd512, "t5 unblocked");
    chk("t5 ref_miss sticky", 32'(ref_miss), 32'd1);

    // 6: asynchronous reset in the middle of a read burst
    wr_trig = 1'b0;
    any = 1'b0;
    for (int n = 0; n < 200 && !any; n++) begin
      if (aref_en) pulse_aref();
      else if (rd_en) any = 1'b1;
      else tick();
    end
    chk("t6 read granted", 32'(any), 32'd1);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("t6 rd_en drop", 32'(rd_en), 32'd0);
    chk("t6 state", 32'(arb_state), 32'd0);
    chk("t6 wr_addr", 32'(wr_addr), 32'd0);
    chk("t6 rd_addr", 32'(rd_addr), 32'd0);
    chk("t6 occ", 32'(dut.occ), 32'd0);
    chk("t6 ref_miss", 32'(ref_miss), 32'd0);
    init_done = 1'b0;
    tick();
    s_rst_n = 1'b1;
    tick();
    tick();
    chk("t6 idle after release", 32'(arb_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
